// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller/sequencer.
// Contents:
//   OP_*       4-bit opcodes (upper nibble of the instruction register)
//   t_state_e  one-hot T-state encoding, bit0 = T1
//   CW_*       bit positions of each strobe inside the control word
//   ctrl_word_t  packed control word type
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam int unsigned CW_PC_INC  = 11;
  localparam int unsigned CW_PC_OE   = 10;
  localparam int unsigned CW_MAR_LD  = 9;
  localparam int unsigned CW_RAM_OE  = 8;
  localparam int unsigned CW_IR_LD   = 7;
  localparam int unsigned CW_IR_OE   = 6;
  localparam int unsigned CW_A_LD    = 5;
  localparam int unsigned CW_A_OE    = 4;
  localparam int unsigned CW_B_LD    = 3;
  localparam int unsigned CW_OUT_LD  = 2;
  localparam int unsigned CW_ALU_SUB = 1;
  localparam int unsigned CW_ALU_OE  = 0;
  localparam int unsigned CW_W       = 12;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/controller_sequencer_if.sv
// Bundle between the SAP-1 sequencer and the datapath/front panel.
//   master : the sequencer (drives strobes, halt, ring_state; reads opcode/run/step)
//   slave  : the datapath/front panel (drives opcode/run/step; reads strobes)
interface controller_sequencer_if;
  logic [3:0] opcode;
  logic       run;
  logic       step;

  logic       pc_increment;
  logic       pc_enable_output;
  logic       mar_load;
  logic       ram_enable_output;
  logic       ir_load;
  logic       ir_enable_output;
  logic       a_load;
  logic       a_enable_output;
  logic       b_load;
  logic       out_load;
  logic       alu_subtract;
  logic       alu_enable_output;
  logic       halt;
  logic [5:0] ring_state;

  modport master (
    input  opcode, run, step,
    output pc_increment, pc_enable_output, mar_load, ram_enable_output,
           ir_load, ir_enable_output, a_load, a_enable_output, b_load,
           out_load, alu_subtract, alu_enable_output, halt, ring_state
  );

  modport slave (
    output opcode, run, step,
    input  pc_increment, pc_enable_output, mar_load, ram_enable_output,
           ir_load, ir_enable_output, a_load, a_enable_output, b_load,
           out_load, alu_subtract, alu_enable_output, halt, ring_state
  );
endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// Six-position one-hot T-state ring.
// Ports:
//   Clock   system clock, rising edge
//   Clear   synchronous active-high clear to T1
//   advance move to the next T-state on this edge
//   state   current one-hot T-state
module ring_counter
  import sap1_pkg::*;
(
  input  logic     Clock,
  input  logic     Clear,
  input  logic     advance,
  output t_state_e state
);

  // Declaration initialiser gives a defined T1 before the first Clear.
  t_state_e state_q = T1;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= T1;
    end else if (advance) begin
      case (state_q)
        T1:      state_q <= T2;
        T2:      state_q <= T3;
        T3:      state_q <= T4;
        T4:      state_q <= T5;
        T5:      state_q <= T6;
        T6:      state_q <= T1;
        default: state_q <= T1;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring plus instruction decode.
// Ports:
//   Clock  system clock, rising edge
//   Clear  synchronous active-high clear (ring -> T1, halt -> 0)
//   bus    controller_sequencer_if.master: opcode/run/step in,
//          control strobes, halt and one-hot ring_state out
// Strobes are combinational from T-state and opcode and are qualified by
// advance, so each one is visible only in the cycle that consumes it.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic                     Clock,
  input  logic                     Clear,
  controller_sequencer_if.master   bus
);

  t_state_e   state;
  logic       halt_q = 1'b0;
  logic       advance;
  logic       hlt_now;
  logic       ring_adv;
  ctrl_word_t cw;

  // step is ORed with run, so a step during free-run adds nothing.
  assign advance  = (bus.run | bus.step) & ~halt_q & ~Clear;
  // HLT freezes the ring at T4 on the edge that sets halt.
  assign hlt_now  = advance && (state == T4) && (bus.opcode == OP_HLT);
  assign ring_adv = advance & ~hlt_now;

  ring_counter u_ring (
    .Clock   (Clock),
    .Clear   (Clear),
    .advance (ring_adv),
    .state   (state)
  );

  always_ff @(posedge Clock) begin
    if (Clear) begin
      halt_q <= 1'b0;
    end else if (hlt_now) begin
      halt_q <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    if (advance) begin
      case (state)
        T1: begin
          cw[CW_PC_OE]  = 1'b1;
          cw[CW_MAR_LD] = 1'b1;
        end
        T2: cw[CW_PC_INC] = 1'b1;
        T3: begin
          cw[CW_RAM_OE] = 1'b1;
          cw[CW_IR_LD]  = 1'b1;
        end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw[CW_IR_OE]  = 1'b1;
              cw[CW_MAR_LD] = 1'b1;
            end
            OP_OUT: begin
              cw[CW_A_OE]   = 1'b1;
              cw[CW_OUT_LD] = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin
              cw[CW_RAM_OE] = 1'b1;
              cw[CW_A_LD]   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_RAM_OE] = 1'b1;
              cw[CW_B_LD]   = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw[CW_ALU_OE]  = 1'b1;
            cw[CW_A_LD]    = 1'b1;
            cw[CW_ALU_SUB] = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_increment      = cw[CW_PC_INC];
  assign bus.pc_enable_output  = cw[CW_PC_OE];
  assign bus.mar_load          = cw[CW_MAR_LD];
  assign bus.ram_enable_output = cw[CW_RAM_OE];
  assign bus.ir_load           = cw[CW_IR_LD];
  assign bus.ir_enable_output  = cw[CW_IR_OE];
  assign bus.a_load            = cw[CW_A_LD];
  assign bus.a_enable_output   = cw[CW_A_OE];
  assign bus.b_load            = cw[CW_B_LD];
  assign bus.out_load          = cw[CW_OUT_LD];
  assign bus.alu_subtract      = cw[CW_ALU_SUB];
  assign bus.alu_enable_output = cw[CW_ALU_OE];
  assign bus.halt              = halt_q;
  assign bus.ring_state        = state;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed self-checking bench for controller_sequencer.
module tb_controller_sequencer;
  import sap1_pkg::*;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  controller_sequencer_if bus ();

  controller_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Strobe vector in a bench-local order, with bench-local bit constants.
  localparam logic [11:0] PCI  = 12'h800;
  localparam logic [11:0] PCE  = 12'h400;
  localparam logic [11:0] MAR  = 12'h200;
  localparam logic [11:0] RAME = 12'h100;
  localparam logic [11:0] IRL  = 12'h080;
  localparam logic [11:0] IRE  = 12'h040;
  localparam logic [11:0] AL   = 12'h020;
  localparam logic [11:0] AE   = 12'h010;
  localparam logic [11:0] BL   = 12'h008;
  localparam logic [11:0] OL   = 12'h004;
  localparam logic [11:0] SUBM = 12'h002;
  localparam logic [11:0] ALUE = 12'h001;

  function automatic logic [11:0] strobes();
    return {bus.pc_increment, bus.pc_enable_output, bus.mar_load,
            bus.ram_enable_output, bus.ir_load, bus.ir_enable_output,
            bus.a_load, bus.a_enable_output, bus.b_load, bus.out_load,
            bus.alu_subtract, bus.alu_enable_output};
  endfunction

  // Bus-contention monitor active for the whole run.
  always @(negedge Clock) begin
    n_checks = n_checks + 1;
    if ($countones({bus.pc_enable_output, bus.ram_enable_output,
                    bus.ir_enable_output, bus.a_enable_output,
                    bus.alu_enable_output}) > 1) begin
      n_fail = n_fail + 1;
      $display("FAIL enable_onehot t=%0t strobes=%h", $time, strobes());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear();
    Clear = 1'b1; bus.run = 1'b0; bus.step = 1'b0;
    next_cycle();
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    // State before any Clear
    n_checks++; if (bus.ring_state !== 6'h01) begin n_fail++; $display("FAIL init_ring got=%h exp=01", bus.ring_state); end
    n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL init_halt got=%b exp=0", bus.halt); end
    next_cycle();
    bus.opcode = OP_LDA; bus.run = 1'b1;
    next_cycle(); next_cycle();
    n_checks++; if (bus.ring_state !== 6'h04) begin n_fail++; $display("FAIL pre_clear_ring got=%h exp=04", bus.ring_state); end
    Clear = 1'b1; bus.step = 1'b1;
    #4;
    n_checks++; if (strobes() !== 12'h000) begin n_fail++; $display("FAIL clear_strobes got=%h exp=000", strobes()); end
    next_cycle();
    Clear = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    n_checks++; if (bus.ring_state !== 6'h01) begin n_fail++; $display("FAIL clear_ring got=%h exp=01", bus.ring_state); end
    n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL clear_halt got=%b exp=0", bus.halt); end
  endtask

  task automatic test_lda();
    logic [5:0]  er [0:6];
    logic [11:0] es [0:5];
    er = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    es = '{PCE|MAR, PCI, RAME|IRL, IRE|MAR, RAME|AL, 12'h000};
    do_clear();
    bus.opcode = OP_LDA; bus.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #4;
      n_checks++; if (bus.ring_state !== er[i]) begin n_fail++; $display("FAIL lda_ring T%0d got=%h exp=%h", i+1, bus.ring_state, er[i]); end
      n_checks++; if (strobes() !== es[i]) begin n_fail++; $display("FAIL lda_strobe T%0d got=%h exp=%h", i+1, strobes(), es[i]); end
      next_cycle();
    end
    n_checks++; if (bus.ring_state !== er[6]) begin n_fail++; $display("FAIL lda_wrap got=%h exp=%h", bus.ring_state, er[6]); end
    bus.run = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [3:0]  ops [0:1];
    logic [11:0] es  [0:5];
    ops = '{OP_ADD, OP_SUB};
    for (int k = 0; k < 2; k++) begin
      es = '{PCE|MAR, PCI, RAME|IRL, IRE|MAR, RAME|BL, (k == 1) ? (ALUE|AL|SUBM) : (ALUE|AL)};
      do_clear();
      bus.opcode = ops[k]; bus.run = 1'b1;
      for (int i = 0; i < 6; i++) begin
        #4;
        n_checks++; if (strobes() !== es[i]) begin n_fail++; $display("FAIL addsub_strobe op=%b T%0d got=%h exp=%h", ops[k], i+1, strobes(), es[i]); end
        next_cycle();
      end
      bus.run = 1'b0;
    end
  endtask

  task automatic test_step();
    logic [5:0]  er [0:6];
    logic [11:0] es [0:5];
    int pci_cycles;
    er = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    es = '{PCE|MAR, PCI, RAME|IRL, IRE|MAR, RAME|AL, 12'h000};
    pci_cycles = 0;
    do_clear();
    bus.opcode = OP_LDA; bus.run = 1'b0;
    for (int p = 0; p < 6; p++) begin
      bus.step = 1'b1;
      #4;
      if (bus.pc_increment === 1'b1) pci_cycles++;
      n_checks++; if (bus.ring_state !== er[p]) begin n_fail++; $display("FAIL step_ring p=%0d got=%h exp=%h", p, bus.ring_state, er[p]); end
      n_checks++; if (strobes() !== es[p]) begin n_fail++; $display("FAIL step_strobe p=%0d got=%h exp=%h", p, strobes(), es[p]); end
      next_cycle();
      bus.step = 1'b0;
      for (int j = 0; j < 3; j++) begin
        #4;
        if (bus.pc_increment === 1'b1) pci_cycles++;
        n_checks++; if (strobes() !== 12'h000) begin n_fail++; $display("FAIL step_idle_strobe p=%0d got=%h exp=000", p, strobes()); end
        n_checks++; if (bus.ring_state !== er[p+1]) begin n_fail++; $display("FAIL step_idle_ring p=%0d got=%h exp=%h", p, bus.ring_state, er[p+1]); end
        next_cycle();
      end
    end
    n_checks++; if (pci_cycles !== 1) begin n_fail++; $display("FAIL step_pc_inc_count got=%0d exp=1", pci_cycles); end
  endtask

  task automatic test_halt();
    logic [11:0] es [0:3];
    es = '{PCE|MAR, PCI, RAME|IRL, 12'h000};
    do_clear();
    bus.opcode = OP_HLT; bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      n_checks++; if (strobes() !== es[i]) begin n_fail++; $display("FAIL hlt_strobe T%0d got=%h exp=%h", i+1, strobes(), es[i]); end
      next_cycle();
    end
    n_checks++; if (bus.halt !== 1'b1) begin n_fail++; $display("FAIL hlt_set got=%b exp=1", bus.halt); end
    n_checks++; if (bus.ring_state !== 6'h08) begin n_fail++; $display("FAIL hlt_ring got=%h exp=08", bus.ring_state); end
    for (int c = 0; c < 20; c++) begin
      bus.step = c[0];
      bus.run  = c[1];
      #4;
      n_checks++; if (bus.ring_state !== 6'h08 || bus.halt !== 1'b1) begin n_fail++; $display("FAIL hlt_hold c=%0d ring=%h halt=%b exp ring=08 halt=1", c, bus.ring_state, bus.halt); end
      n_checks++; if (strobes() !== 12'h000) begin n_fail++; $display("FAIL hlt_hold_strobe c=%0d got=%h exp=000", c, strobes()); end
      next_cycle();
    end
    bus.run = 1'b1; bus.step = 1'b0;
    Clear = 1'b1;
    #4;
    n_checks++; if (strobes() !== 12'h000) begin n_fail++; $display("FAIL hlt_clear_strobe got=%h exp=000", strobes()); end
    next_cycle();
    Clear = 1'b0; bus.run = 1'b0;
    n_checks++; if (bus.ring_state !== 6'h01) begin n_fail++; $display("FAIL hlt_clear_ring got=%h exp=01", bus.ring_state); end
    n_checks++; if (bus.halt !== 1'b0) begin n_fail++; $display("FAIL hlt_clear_halt got=%b exp=0", bus.halt); end
  endtask

  task automatic test_mid_clear();
    logic [11:0] es [0:2];
    es = '{PCE|MAR, PCI, RAME|IRL};
    do_clear();
    bus.opcode = OP_ADD; bus.run = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    Clear = 1'b1;
    #4;
    n_checks++; if (bus.ring_state !== 6'h10) begin n_fail++; $display("FAIL mid_ring_t5 got=%h exp=10", bus.ring_state); end
    n_checks++; if (strobes() !== 12'h000) begin n_fail++; $display("FAIL mid_clear_strobe got=%h exp=000", strobes()); end
    next_cycle();
    Clear = 1'b0;
    n_checks++; if (bus.ring_state !== 6'h01) begin n_fail++; $display("FAIL mid_clear_ring got=%h exp=01", bus.ring_state); end
    for (int i = 0; i < 3; i++) begin
      #4;
      n_checks++; if (strobes() !== es[i]) begin n_fail++; $display("FAIL mid_refetch T%0d got=%h exp=%h", i+1, strobes(), es[i]); end
      next_cycle();
    end
    bus.run = 1'b0;
  endtask

  task automatic test_nop();
    logic [5:0]  er [0:6];
    logic [11:0] es [0:5];
    er = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    es = '{PCE|MAR, PCI, RAME|IRL, 12'h000, 12'h000, 12'h000};
    do_clear();
    bus.opcode = 4'b0101; bus.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #4;
      n_checks++; if (bus.ring_state !== er[i]) begin n_fail++; $display("FAIL nop_ring T%0d got=%h exp=%h", i+1, bus.ring_state, er[i]); end
      n_checks++; if (strobes() !== es[i]) begin n_fail++; $display("FAIL nop_strobe T%0d got=%h exp=%h", i+1, strobes(), es[i]); end
      next_cycle();
    end
    n_checks++; if (bus.ring_state !== er[6]) begin n_fail++; $display("FAIL nop_wrap got=%h exp=01", bus.ring_state); end
    bus.run = 1'b0;
  endtask

  task automatic test_out_run_step();
    logic [5:0]  er [0:3];
    logic [11:0] es [0:5];
    er = '{6'h01, 6'h02, 6'h04, 6'h08};
    es = '{PCE|MAR, PCI, RAME|IRL, AE|OL, 12'h000, 12'h000};
    do_clear();
    bus.opcode = OP_OUT; bus.run = 1'b1; bus.step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #4;
      if (i < 4) begin
        n_checks++; if (bus.ring_state !== er[i]) begin n_fail++; $display("FAIL runstep_ring T%0d got=%h exp=%h", i+1, bus.ring_state, er[i]); end
      end
      n_checks++; if (strobes() !== es[i]) begin n_fail++; $display("FAIL out_strobe T%0d got=%h exp=%h", i+1, strobes(), es[i]); end
      next_cycle();
    end
    bus.run = 1'b0; bus.step = 1'b0;
  endtask

  initial begin
    bus.opcode = OP_LDA;
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    #1;
    test_reset();
    test_lda();
    test_add_sub();
    test_step();
    test_halt();
    test_mid_clear();
    test_nop();
    test_out_run_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 Parameters: none; opcodes and T-state encodings SHALL come from the shared package.
REQ-002 Clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Clear  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  4  instruction register upper nibble; valid from T4 onward.
REQ-005 run  input  1  1 = free-run (advance every cycle); 0 = single-step.
REQ-006 step  input  1  one-cycle pulse, already synchronized; advances one T-state when run=0.
REQ-007 pc_increment, pc_enable_output  output  1 each  program counter increment and bus drive.
REQ-008 mar_load, ram_enable_output  output  1 each  MAR load and RAM bus drive.
REQ-009 ir_load, ir_enable_output  output  1 each  IR load and IR operand-nibble bus drive.
REQ-010 a_load, a_enable_output, b_load, out_load  output  1 each  register load and drive strobes.
REQ-011 alu_subtract, alu_enable_output  output  1 each  ALU mode (1 = A-B) and ALU bus drive.
REQ-012 halt  output  1  high while halted.
REQ-013 ring_state  output  6  one-hot T-state (bit0 = T1) for LED indicators; always driven.

Function
REQ-014 T-states SHALL cycle T1->T2->...->T6->T1; the state SHALL move only on a rising edge where advance = (run | step) & ~halt & ~Clear.
REQ-015 Control outputs SHALL be combinational from state and opcode, and SHALL be 0 in any cycle where advance=0, so no strobe is ever seen twice.
REQ-016 Fetch SHALL be opcode-independent: T1 pc_enable_output+mar_load; T2 pc_increment; T3 ram_enable_output+ir_load.
REQ-017 LDA (0000) SHALL assert: T4 ir_enable_output+mar_load; T5 ram_enable_output+a_load; T6 none.
REQ-018 ADD (0001) SHALL assert: T4 ir_enable_output+mar_load; T5 ram_enable_output+b_load; T6 alu_enable_output+a_load, alu_subtract=0.
REQ-019 SUB (0010) SHALL assert the same signals as ADD, with alu_subtract=1 in T6.
REQ-020 OUT (1110) SHALL assert: T4 a_enable_output+out_load; T5, T6 none.
REQ-021 HLT (1111) SHALL assert no strobes in T4; on that advancing edge halt SHALL set and ring_state SHALL remain T4.
REQ-022 Any other opcode SHALL be a NOP: no strobes in T4-T6, with normal advance.
REQ-023 At most one *_enable_output SHALL be high in any cycle.
REQ-024 While halt=1, all strobes SHALL be 0 and run/step SHALL be ignored; only Clear SHALL exit.
REQ-025 A step pulse while run=1 SHALL have no additional effect (one advance per cycle maximum).

Reset
REQ-026 Clear=1 at a rising edge SHALL set ring_state=000001 (T1) and halt=0, overriding run, step and halt.
REQ-027 During any cycle with Clear=1, all strobes SHALL be 0. A mid-instruction Clear SHALL abandon the instruction without emitting any further strobes for it.
REQ-028 Before the first Clear, ring_state SHALL initialise to T1 and halt to 0, for simulation determinism.

Structure
REQ-029 Shared package sap1_pkg SHALL hold the opcode constants (LDA, ADD, SUB, OUT, HLT), the T1-T6 one-hot constants and the control-word bit indices.
REQ-030 The 6-bit one-hot ring with advance and Clear inputs SHALL be a sub-module named ring_counter; decode and halt logic SHALL stay in controller_sequencer.

Verification
REQ-031 Clear, run=1, opcode=0000 -> T1..T6 strobes exactly as in REQ-016/017; ring_state sequence 01,02,04,08,10,20,01 hex.
REQ-032 run=1, opcode=0010 -> T6 shows alu_enable_output=1, a_load=1, alu_subtract=1; the same test with opcode=0001 gives alu_subtract=0.
REQ-033 run=0, step pulses spaced by 3 idle cycles -> exactly one advance per pulse; strobes high only in the pulse cycles; pc_increment high for exactly 1 cycle per instruction.
REQ-034 opcode=1111 reaching T4 -> halt=1 next cycle, ring_state=08 hex held for 20 cycles with all strobes 0; Clear -> ring_state=01, halt=0.
REQ-035 Clear asserted in T5 of ADD -> no b_load or a_load follows; next cycle ring_state=01; the next instruction fetches normally.
REQ-036 Assertion running in all tests: the count of *_enable_output high is at most 1 every cycle; opcode=0101 runs as a NOP with no strobes in T4-T6.
